// File: rtl/mdio_cfg_sequencer.sv
// mdio_cfg_sequencer: walks an external PHY register table and issues MDIO
// write frames to the MDIO master over its cmd/new_cmd/rdy handshake.
// With MDIO_CFG_VERIFY_EN defined, every write is read back, compared under
// the entry mask, and retried up to MAX_RETRY times before aborting.
module mdio_cfg_sequencer #(
   parameter int unsigned NUM_ENTRIES = 32,
   parameter int unsigned IDX_W       = 8,
   parameter logic [4:0]  PHY_ADDR    = 5'd0,
   parameter int unsigned MAX_RETRY   = 2,
   parameter int unsigned TIMEOUT     = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   output logic [IDX_W-1:0] o_tbl_idx,
   input  logic [4:0]       i_tbl_regad,
   input  logic [15:0]      i_tbl_data,
   input  logic [15:0]      i_tbl_mask,
   output logic [31:0]      o_cmd,
   output logic             o_new_cmd,
   input  logic             i_rdy,
   input  logic             i_rd_valid,
   input  logic [15:0]      i_rd_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [IDX_W-1:0] o_err_idx,
   output logic             o_err_timeout
);

   localparam int unsigned   TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_ISSUE,
      S_WR_WAIT,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_CHECK,
      S_NEXT,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      cmd_q, cmd_d;
   logic             new_cmd_q, new_cmd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [IDX_W-1:0] err_idx_q, err_idx_d;
   logic             err_tmo_q, err_tmo_d;
   logic             pend_tmo_q, pend_tmo_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             low_seen_q, low_seen_d;
   logic             tmo_expired;

`ifdef MDIO_CFG_VERIFY_EN
   logic [2:0]       retry_q, retry_d;
   logic [15:0]      rd_data_q, rd_data_d;
`else
   logic             unused_rd;
   assign unused_rd = ^{i_tbl_mask, i_rd_valid, i_rd_data};
`endif

   function automatic logic [31:0] mk_frame(input logic [1:0]  op,
                                            input logic [4:0]  regad,
                                            input logic [15:0] data);
      return {2'b01, op, PHY_ADDR, regad, 2'b10, data};
   endfunction

   assign tmo_expired = (tmo_q == TMO_LAST);

   // Sequencer next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cmd_d      = cmd_q;
      new_cmd_d  = 1'b0;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      err_idx_d  = err_idx_q;
      err_tmo_d  = err_tmo_q;
      pend_tmo_d = pend_tmo_q;
      low_seen_d = low_seen_q;
      tmo_d      = tmo_q + TMO_W'(1);
`ifdef MDIO_CFG_VERIFY_EN
      retry_d    = retry_q;
      rd_data_d  = rd_data_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               done_d    = 1'b0;
               error_d   = 1'b0;
               err_idx_d = '0;
               err_tmo_d = 1'b0;
               idx_d     = '0;
               busy_d    = 1'b1;
               state_d   = S_WR_ISSUE;
            end
         end
         S_WR_ISSUE: begin
            if (i_rdy) begin
               cmd_d      = mk_frame(2'b01, i_tbl_regad, i_tbl_data);
               new_cmd_d  = 1'b1;
               low_seen_d = 1'b0;
               state_d    = S_WR_WAIT;
            end else if (tmo_expired) begin
               pend_tmo_d = 1'b1;
               state_d    = S_ERR;
            end
         end
         S_WR_WAIT: begin
            if (!i_rdy) low_seen_d = 1'b1;
            // rdy still high two cycles after the strobe means the master
            // already finished a one-cycle busy phase we never observed.
            if (i_rdy && (low_seen_q || tmo_q >= TMO_W'(2))) begin
`ifdef MDIO_CFG_VERIFY_EN
               state_d = S_RD_ISSUE;
`else
               state_d = S_NEXT;
`endif
            end else if (tmo_expired) begin
               pend_tmo_d = 1'b1;
               state_d    = S_ERR;
            end
         end
`ifdef MDIO_CFG_VERIFY_EN
         S_RD_ISSUE: begin
            if (i_rdy) begin
               cmd_d     = mk_frame(2'b10, i_tbl_regad, 16'h0000);
               new_cmd_d = 1'b1;
               state_d   = S_RD_WAIT;
            end else if (tmo_expired) begin
               pend_tmo_d = 1'b1;
               state_d    = S_ERR;
            end
         end
         S_RD_WAIT: begin
            if (i_rd_valid) begin
               rd_data_d = i_rd_data;
               state_d   = S_CHECK;
            end else if (tmo_expired) begin
               pend_tmo_d = 1'b1;
               state_d    = S_ERR;
            end
         end
         S_CHECK: begin
            if (((rd_data_q ^ i_tbl_data) & i_tbl_mask) == 16'h0000) begin
               state_d = S_NEXT;
            end else if (retry_q < 3'(MAX_RETRY)) begin
               retry_d = retry_q + 3'd1;
               state_d = S_WR_ISSUE;
            end else begin
               pend_tmo_d = 1'b0;
               state_d    = S_ERR;
            end
         end
`endif
         S_NEXT: begin
`ifdef MDIO_CFG_VERIFY_EN
            retry_d = '0;
`endif
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_WR_ISSUE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ERR: begin
            error_d   = 1'b1;
            err_idx_d = idx_q;
            err_tmo_d = pend_tmo_q;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Every state change restarts the handshake timer.
      if (state_d != state_q || state_q == S_IDLE) tmo_d = '0;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cmd_q      <= '0;
         new_cmd_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_idx_q  <= '0;
         err_tmo_q  <= 1'b0;
         pend_tmo_q <= 1'b0;
         low_seen_q <= 1'b0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cmd_q      <= cmd_d;
         new_cmd_q  <= new_cmd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_idx_q  <= err_idx_d;
         err_tmo_q  <= err_tmo_d;
         pend_tmo_q <= pend_tmo_d;
         low_seen_q <= low_seen_d;
         tmo_q      <= tmo_d;
      end
   end

`ifdef MDIO_CFG_VERIFY_EN
   // Read-back capture and retry counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retry_q   <= '0;
         rd_data_q <= '0;
      end else begin
         retry_q   <= retry_d;
         rd_data_q <= rd_data_d;
      end
   end
`endif

   assign o_tbl_idx     = idx_q;
   assign o_cmd         = cmd_q;
   assign o_new_cmd     = new_cmd_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_error       = error_q;
   assign o_err_idx     = err_idx_q;
   assign o_err_timeout = err_tmo_q;

endmodule

// File: doc/mdio_cfg_sequencer.md
Name: mdio_cfg_sequencer

Overview:
- Synthesizable successor to the 32-register write/read-back bring-up sequence.
- Walks a parametrised table of PHY register entries (address, value, compare mask) and issues MDIO write commands to the existing MDIO master over its cmd/new_cmd/rdy handshake.
- Optionally reads each register back, compares under mask and retries. Reports done/error status to the Ethernet bring-up logic.
- Sits between the board init controller and the MDIO master; the configuration table is external (ROM/regfile) and indexed by this block.

Parameters:
- NUM_ENTRIES, 32, number of table entries processed (1..256).
- IDX_W, 8, width of table index; must be >= clog2(NUM_ENTRIES).
- PHY_ADDR, 5'd0, PHY address placed in every frame.
- MAX_RETRY, 2, write+readback retries per entry before error (0..7).
- TIMEOUT, 4096, clk cycles allowed per handshake wait before error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- i_start  in  1  pulse; starts sequence from entry 0 when idle.
- o_tbl_idx  out  IDX_W  current table index.
- i_tbl_regad  in  5  register address of entry o_tbl_idx (valid same cycle, combinational table).
- i_tbl_data  in  16  value to write.
- i_tbl_mask  in  16  compare mask for readback (1 = compared bit).
- o_cmd  out  32  MDIO frame: [31:30]=ST 01, [29:28]=OP (01 write, 10 read), [27:23]=PHY_ADDR, [22:18]=REGAD, [17:16]=TA 10, [15:0]=data (0 for read).
- o_new_cmd  out  1  one-cycle command strobe.
- i_rdy  in  1  master idle/ready.
- i_rd_valid  in  1  one-cycle pulse, read data valid.
- i_rd_data  in  16  read data.
- o_busy  out  1  sequence in progress.
- o_done  out  1  sticky: sequence finished without error.
- o_error  out  1  sticky: sequence aborted.
- o_err_idx  out  IDX_W  index of failing entry.
- o_err_timeout  out  1  1 = abort caused by timeout, 0 = by mismatch.

Behaviour:
- Reset (any time, including mid-transfer): state IDLE; all outputs 0; retry/timeout counters 0. No frame is issued after reset deassertion until i_start.
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CHECK, NEXT, DONE, ERR.
- IDLE:
  - i_start=1 clears o_done/o_error/o_err_*, sets o_tbl_idx=0, o_busy=1, and goes to WR_ISSUE.
  - i_start while busy is ignored.
- WR_ISSUE: waits for i_rdy=1, then drives o_cmd (OP=01, data=i_tbl_data) with o_new_cmd=1 for exactly one cycle, then WR_WAIT.
- WR_WAIT:
  - Waits for i_rdy to fall then rise (write complete).
  - i_rdy still high after 2 cycles counts as the fall having happened, so a single-cycle-busy master is tolerated.
  - Then RD_ISSUE if readback is enabled, else NEXT.
- RD_ISSUE: same as WR_ISSUE with OP=10, data field 0, then RD_WAIT.
- RD_WAIT: captures i_rd_data on i_rd_valid, then CHECK.
- CHECK:
  - Pass if ((i_rd_data ^ i_tbl_data) & i_tbl_mask) == 0; a pass goes to NEXT.
  - On mismatch with retry count < MAX_RETRY: increment retry count, go to WR_ISSUE.
  - Otherwise go to ERR with o_err_timeout=0.
- NEXT: retry count cleared. If o_tbl_idx == NUM_ENTRIES-1, go to DONE; else increment the index and go to WR_ISSUE. The index never wraps.
- DONE: o_done=1, o_busy=0, go to IDLE.
- ERR: o_error=1, o_err_idx=failing index, o_busy=0, go to IDLE.
- Timeout counter restarts on entry to every ISSUE/WAIT state. Reaching TIMEOUT goes to ERR with o_err_timeout=1.
- o_cmd holds its last value between strobes. o_tbl_idx is stable for the whole entry, including retries.
- i_rd_valid outside RD_WAIT is ignored.
- A simultaneous i_start and DONE/ERR transition is ignored; i_start is only sampled in IDLE.

Optional Feature:
- MDIO_CFG_VERIFY_EN defined: readback path (RD_ISSUE, RD_WAIT, CHECK), retries and mismatch errors are implemented.
- Not defined: each entry is write-only (WR_WAIT goes straight to NEXT). i_tbl_mask, i_rd_valid and i_rd_data are unused. o_error is raised only by timeout.

Test Plan:
- NUM_ENTRIES=32, emulator PHY echoes writes; pulse i_start -> 32 write frames, e.g. entry 0 frame 0x5002_1140 for regad 0 data 0x1140 at PHY_ADDR 0. With verify, 32 reads follow, each after its write; o_done=1, o_error=0.
- Emulator forces reg 2 bit 0 stuck; entry 2 data 0x0141 mask 0xFFFF, MAX_RETRY=2 -> 3 write/read pairs on idx 2, then o_error=1, o_err_idx=2, o_err_timeout=0, no frame for idx 3.
- Same stuck bit with mask 0xFFFE -> passes, o_done=1.
- i_rdy held low after the first write strobe, TIMEOUT=64 -> o_error=1, o_err_timeout=1, o_err_idx=0 at 64 cycles.
- Assert reset during RD_WAIT of entry 5 -> all outputs 0 next edge. A later i_start restarts at idx 0.
- Second i_start pulse mid-sequence -> ignored, frame count unchanged (32 writes, plus 32 reads with verify).
